// File: rtl/id_operand_stage.sv
// Decode-stage operand front end: IF->ID register with SRAM hold buffer, regfile,
// priority forwarding, load-use stall detection and a saturating stall counter.
module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_in,
    input  logic                      flush,
    input  logic                      if_valid,
    input  logic [31:0]               if_pc,
    input  logic [31:0]               inst_sram_rdata,
    input  logic                      use_rs,
    input  logic                      use_rt,
    input  logic                      rf_we,
    input  logic [REG_AW-1:0]         rf_waddr,
    input  logic [DATA_W-1:0]         rf_wdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    output logic                      id_valid,
    output logic [31:0]               id_pc,
    output logic [31:0]               inst_out,
    output logic [DATA_W-1:0]         rdata1,
    output logic [DATA_W-1:0]         rdata2,
    output logic                      stallreq,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int NREG = 2 ** REG_AW;

    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } hold_state_e;

    hold_state_e state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] raw_inst;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0][REG_AW-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0]             rd_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall_in) begin
            pc_q    <= if_pc;
            valid_q <= if_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LIVE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // The SRAM only presents data for one cycle, so the first stalled word is captured.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            LIVE: begin
                if (stall_in && !flush) begin
                    hold_d  = inst_sram_rdata;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (flush || !stall_in) begin
                    state_d = LIVE;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    assign raw_inst = (state_q == HELD) ? hold_q : inst_sram_rdata;
    assign inst_out = valid_q ? raw_inst : 32'h0;
    assign id_pc    = pc_q;
    assign rd_addr[0] = REG_AW'(inst_out[25:21]);
    assign rd_addr[1] = REG_AW'(inst_out[20:16]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else if (rf_we && rf_waddr != '0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Scanning from the oldest source down lets the youngest match overwrite the result.
    always_comb begin
        rd_data   = '0;
        rd_hazard = '0;
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = (rf_we && rf_waddr == rd_addr[p]) ? rf_wdata : regs_q[rd_addr[p]];
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_we[i] && fwd_waddr[i*REG_AW +: REG_AW] == rd_addr[p]) begin
                    rd_data[p]   = fwd_wdata[i*DATA_W +: DATA_W];
                    rd_hazard[p] = fwd_is_load[i];
                end
            end
            if (rd_addr[p] == '0) begin
                rd_data[p]   = '0;
                rd_hazard[p] = 1'b0;
            end
        end
    end

    assign rdata1   = rd_data[0];
    assign rdata2   = rd_data[1];
    assign stallreq = valid_q & ((use_rs & rd_hazard[0]) | (use_rt & rd_hazard[1]));
    assign id_valid = valid_q & ~stallreq & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stallreq && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst, stall_in, flush, if_valid;
    logic [31:0] if_pc, inst_sram_rdata;
    logic        use_rs, use_rt, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  fwd_we, fwd_is_load;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_wdata;

    logic        id_valid, stallreq;
    logic [31:0] id_pc, inst_out, rdata1, rdata2;
    logic [15:0] stall_cycles;

    logic        s_id_valid, s_stallreq;
    logic [31:0] s_id_pc, s_inst_out, s_rdata1, s_rdata2;
    logic [3:0]  s_stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .if_valid(if_valid),
        .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata), .use_rs(use_rs), .use_rt(use_rt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_we(fwd_we),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
        .id_valid(id_valid), .id_pc(id_pc), .inst_out(inst_out), .rdata1(rdata1),
        .rdata2(rdata2), .stallreq(stallreq), .stall_cycles(stall_cycles)
    );

    id_operand_stage #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .if_valid(if_valid),
        .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata), .use_rs(use_rs), .use_rt(use_rt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_we(fwd_we),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
        .id_valid(s_id_valid), .id_pc(s_id_pc), .inst_out(s_inst_out), .rdata1(s_rdata1),
        .rdata2(s_rdata2), .stallreq(s_stallreq), .stall_cycles(s_stall_cycles)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state describes the stage as it will be after the next rising edge.
    logic [31:0] m_regs [32];
    bit          m_known = 1'b0;
    logic        m_valid;
    logic [31:0] m_pc;
    bit          m_frozen;
    logic [31:0] m_frozen_inst;
    int          m_cnt, m_cnt4;

    logic [31:0] e_raw, e_inst, e_r1, e_r2;
    logic        e_h1, e_h2, e_stall, e_idv;

    function automatic void modelOperand(input logic [4:0] a, output logic [31:0] d, output logic hz);
        bit found = 1'b0;
        d  = (rf_we && rf_waddr == a) ? rf_wdata : m_regs[a];
        hz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && fwd_we[i] && fwd_waddr[i*5 +: 5] == a) begin
                found = 1'b1;
                d     = fwd_wdata[i*32 +: 32];
                hz    = fwd_is_load[i];
            end
        end
        if (a == 5'd0) begin
            d  = 32'h0;
            hz = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            e_raw  = m_frozen ? m_frozen_inst : inst_sram_rdata;
            e_inst = m_valid ? e_raw : 32'h0;
            modelOperand(e_inst[25:21], e_r1, e_h1);
            modelOperand(e_inst[20:16], e_r2, e_h2);
            e_stall = m_valid && ((use_rs && e_h1) || (use_rt && e_h2));
            e_idv   = m_valid && !e_stall && !flush;
            checkOutput("id_valid", 32'(id_valid), 32'(e_idv));
            checkOutput("id_pc", id_pc, m_pc);
            checkOutput("inst_out", inst_out, e_inst);
            checkOutput("rdata1", rdata1, e_r1);
            checkOutput("rdata2", rdata2, e_r2);
            checkOutput("stallreq", 32'(stallreq), 32'(e_stall));
            checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
            checkOutput("stall_cycles_w4", 32'(s_stall_cycles), 32'(m_cnt4));
        end else begin
            e_stall = 1'b0;
        end
        if (rst) begin
            m_known  = 1'b1;
            m_valid  = 1'b0;
            m_pc     = 32'h0;
            m_frozen = 1'b0;
            m_cnt    = 0;
            m_cnt4   = 0;
            for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        end else if (m_known) begin
            if (flush) begin
                m_valid  = 1'b0;
                m_frozen = 1'b0;
            end else if (!stall_in) begin
                m_pc     = if_pc;
                m_valid  = if_valid;
                m_frozen = 1'b0;
            end else if (!m_frozen) begin
                m_frozen      = 1'b1;
                m_frozen_inst = inst_sram_rdata;
            end
            if (rf_we && rf_waddr != 5'd0) m_regs[rf_waddr] = rf_wdata;
            if (e_stall && m_cnt < 65535) m_cnt++;
            if (e_stall && m_cnt4 < 15) m_cnt4++;
        end
    end

    task automatic clearInputs();
        rst = 1'b0; stall_in = 1'b0; flush = 1'b0; if_valid = 1'b0;
        if_pc = 32'h0; inst_sram_rdata = 32'h0; use_rs = 1'b0; use_rt = 1'b0;
        rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'h0;
        fwd_we = 3'b000; fwd_is_load = 3'b000; fwd_waddr = '0; fwd_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        rst      = ($urandom_range(0, 63) == 0);
        flush    = ($urandom_range(0, 15) == 0);
        stall_in = ($urandom_range(0, 2) == 0);
        if_valid = ($urandom_range(0, 3) != 0);
        if_pc    = $urandom;
        inst_sram_rdata = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        use_rs   = 1'($urandom_range(0, 1));
        use_rt   = 1'($urandom_range(0, 1));
        rf_we    = 1'($urandom_range(0, 1));
        rf_waddr = 5'($urandom_range(0, 7));
        rf_wdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            fwd_we[i]            = ($urandom_range(0, 2) != 0);
            fwd_is_load[i]       = ($urandom_range(0, 2) == 0);
            fwd_waddr[i*5 +: 5]  = 5'($urandom_range(0, 7));
            fwd_wdata[i*32 +: 32] = $urandom;
        end
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        checkOutput("reset_id_valid", 32'(id_valid), 32'h0);
        checkOutput("reset_id_pc", id_pc, 32'h0);
        checkOutput("reset_inst_out", inst_out, 32'h0);
        checkOutput("reset_stallreq", 32'(stallreq), 32'h0);
        checkOutput("reset_stall_cycles", 32'(stall_cycles), 32'h0);
        tick();

        rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'h11;
        tick();
        rf_we = 1'b0;

        // Instruction buffer must survive three stalled cycles and the release cycle.
        if_valid = 1'b1; if_pc = 32'hBFC0_0000;
        tick();
        inst_sram_rdata = 32'h3C01_1234; stall_in = 1'b1;
        #2;
        checkOutput("hold_first", inst_out, 32'h3C01_1234);
        checkOutput("hold_pc", id_pc, 32'hBFC0_0000);
        tick();
        for (int k = 0; k < 2; k++) begin
            inst_sram_rdata = 32'hFFFF_FFFF; stall_in = 1'b1;
            #2;
            checkOutput("hold_stalled", inst_out, 32'h3C01_1234);
            tick();
        end
        stall_in = 1'b0; if_pc = 32'hBFC0_0004;
        #2;
        checkOutput("hold_release", inst_out, 32'h3C01_1234);
        tick();

        inst_sram_rdata = 32'h00A0_0000; use_rs = 1'b1;
        #2;
        checkOutput("live_inst", inst_out, 32'h00A0_0000);
        checkOutput("live_pc", id_pc, 32'hBFC0_0004);
        checkOutput("rf_plain", rdata1, 32'h11);
        tick();

        fwd_we = 3'b111;
        fwd_waddr = {5'd5, 5'd5, 5'd5};
        fwd_wdata = {32'hCC, 32'hBB, 32'hAA};
        #2;
        checkOutput("fwd_prio_src0", rdata1, 32'hAA);
        tick();
        fwd_we = 3'b110;
        #2;
        checkOutput("fwd_prio_src1", rdata1, 32'hBB);
        tick();
        fwd_we = 3'b000; rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'h77;
        #2;
        checkOutput("write_through", rdata1, 32'h77);
        tick();
        rf_we = 1'b0;

        inst_sram_rdata = 32'h0; fwd_we = 3'b001; fwd_is_load = 3'b001;
        fwd_waddr = 15'd0; fwd_wdata = {64'h0, 32'hDEAD};
        #2;
        checkOutput("zero_rdata1", rdata1, 32'h0);
        checkOutput("zero_stallreq", 32'(stallreq), 32'h0);
        tick();

        inst_sram_rdata = 32'h0008_0000; use_rs = 1'b0; use_rt = 1'b1;
        fwd_we = 3'b001; fwd_is_load = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd8};
        #2;
        checkOutput("loaduse_stallreq", 32'(stallreq), 32'h1);
        checkOutput("loaduse_id_valid", 32'(id_valid), 32'h0);
        checkOutput("loaduse_cnt_before", 32'(stall_cycles), 32'h0);
        tick();
        use_rt = 1'b0;
        #2;
        checkOutput("loaduse_cnt_after", 32'(stall_cycles), 32'h1);
        checkOutput("loaduse_unused_rt", 32'(stallreq), 32'h0);
        tick();
        use_rt = 1'b1; fwd_we = 3'b011; fwd_is_load = 3'b010; fwd_waddr = {5'd0, 5'd8, 5'd8};
        #2;
        checkOutput("shadowed_load", 32'(stallreq), 32'h0);
        checkOutput("shadowed_id_valid", 32'(id_valid), 32'h1);
        tick();

        fwd_we = 3'b001; fwd_is_load = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd8};
        for (int k = 0; k < 20; k++) tick();
        #2;
        checkOutput("sat_w4", 32'(s_stall_cycles), 32'd15);
        checkOutput("sat_w16", 32'(stall_cycles), 32'd21);
        tick();
        #2;
        checkOutput("sat_w4_stays", 32'(s_stall_cycles), 32'd15);
        checkOutput("sat_w16_next", 32'(stall_cycles), 32'd22);
        tick();

        // Flush while the hold buffer is occupied.
        clearInputs();
        if_valid = 1'b1; if_pc = 32'h100;
        tick();
        inst_sram_rdata = 32'h1234_5678; stall_in = 1'b1;
        #2;
        checkOutput("flush_pre", inst_out, 32'h1234_5678);
        tick();
        inst_sram_rdata = 32'hFFFF_FFFF; flush = 1'b1;
        #2;
        checkOutput("flush_held", inst_out, 32'h1234_5678);
        checkOutput("flush_id_valid", 32'(id_valid), 32'h0);
        tick();
        flush = 1'b0; stall_in = 1'b0; if_pc = 32'h104;
        #2;
        checkOutput("post_flush_inst", inst_out, 32'h0);
        checkOutput("post_flush_id_valid", 32'(id_valid), 32'h0);
        tick();
        inst_sram_rdata = 32'h0BAD_F00D;
        #2;
        checkOutput("post_flush_live", inst_out, 32'h0BAD_F00D);
        checkOutput("post_flush_pc", id_pc, 32'h104);
        tick();

        // Reset while the hold buffer is occupied; regfile must come back cleared.
        inst_sram_rdata = 32'h00A0_0000; stall_in = 1'b1;
        tick();
        rst = 1'b1; inst_sram_rdata = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0; stall_in = 1'b0; if_pc = 32'h200; inst_sram_rdata = 32'h00A0_0000; use_rs = 1'b1;
        #2;
        checkOutput("rst_held_inst", inst_out, 32'h0);
        checkOutput("rst_held_id_valid", 32'(id_valid), 32'h0);
        checkOutput("rst_held_pc", id_pc, 32'h0);
        checkOutput("rst_held_stallreq", 32'(stallreq), 32'h0);
        checkOutput("rst_held_cnt", 32'(stall_cycles), 32'h0);
        tick();
        #2;
        checkOutput("rst_regfile_inst", inst_out, 32'h00A0_0000);
        checkOutput("rst_regfile_r5", rdata1, 32'h0);
        checkOutput("rst_regfile_pc", id_pc, 32'h200);
        tick();

        for (int n = 0; n < 2000; n++) begin
            applyStimulus();
            tick();
        end
        clearInputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
